// File: rtl/psk_tx_frame_ctrl_pkg.sv
// Shared types and constants for the PSK transmit frame sequencer.
// Holds the FSM state encoding, fixed header bytes and the output byte record.
package psk_tx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SYNC = 3'd2,
        ST_LEN  = 3'd3,
        ST_PAY  = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    localparam logic [7:0]  PRE_BYTE      = 8'h55;
    localparam logic [7:0]  PAD_BYTE      = 8'h00;
    localparam logic [15:0] DEF_SYNC_WORD = 16'hD391;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } psk_byte_t;

    function automatic psk_byte_t mk_byte(input logic [7:0] data, input logic last, input logic user);
        psk_byte_t b;
        b.data = data;
        b.last = last;
        b.user = user;
        return b;
    endfunction

endpackage

// File: rtl/psk_tx_frame_ctrl_if.sv
// Byte streams around the frame sequencer: payload source in, modulator stream out.
// slave = sequencer side, master = the source/modulator side driving it.
interface psk_tx_frame_ctrl_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;
    logic [7:0] psk_tdata;
    logic       psk_tvalid;
    logic       psk_tlast;
    logic       psk_tuser;
    logic       psk_tready;

    modport master (
        output s_tdata, s_tvalid, s_tlast, psk_tready,
        input  s_tready, psk_tdata, psk_tvalid, psk_tlast, psk_tuser
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, psk_tready,
        output s_tready, psk_tdata, psk_tvalid, psk_tlast, psk_tuser
    );
endinterface

// File: rtl/psk_tx_out_reg.sv
// One-entry output register for the modulator byte stream.
// Latency: 1 cycle from in_vld&in_rdy to out_vld.
// Backpressure: contents held while out_vld&!out_rdy; accepts a new byte when empty or draining.
module psk_tx_out_reg
    import psk_tx_frame_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_vld,
    input  psk_byte_t in_dat,
    output logic      in_rdy,
    output logic      out_vld,
    output psk_byte_t out_dat,
    input  logic      out_rdy
);

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/psk_tx_frame_ctrl.sv
// Frame sequencer for the PSK modulator: preamble, sync, length, payload, then a guard gap.
// Latency: first preamble byte valid one cycle after an accepted start; 1 byte/clk sustained.
// Backpressure: psk_tready stalls the output register; source is read only when it can drain.
module psk_tx_frame_ctrl
    import psk_tx_frame_ctrl_pkg::*;
#(
    parameter int          PRE_BYTES  = 8,
    parameter logic [15:0] SYNC_WORD  = DEF_SYNC_WORD,
    parameter int          GAP_CYCLES = 64
) (
    input  logic                 clk_32d768M,
    input  logic                 rst_n_32d768M,
    input  logic                 clk_16d384M,
    input  logic                 start,
    input  logic [7:0]           cfg_len,
    input  logic                 cfg_bpsk,
    input  logic [15:0]          cfg_phase_inc,
    input  logic [3:0]           cfg_delay,
    psk_tx_frame_ctrl_if.slave   io,
    output logic [15:0]          TX_PHASE_CONFIG,
    output logic [3:0]           DELAY_CNT,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_len,
    output logic                 err_cfg
);

    localparam logic [7:0] PRE_LAST = 8'(PRE_BYTES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    state_t      state_q, state_nxt;
    logic [7:0]  cnt_q, cnt_nxt;
    logic [7:0]  gap_q, gap_nxt;
    logic [7:0]  len_q, len_nxt;
    logic        bpsk_q, bpsk_nxt;
    logic [15:0] phase_q, phase_nxt;
    logic [3:0]  delay_q, delay_nxt;
    logic        err_len_q, err_len_nxt;
    logic        src_done_q, src_done_nxt;
    logic        done_q, done_nxt;
    logic        err_cfg_q, err_cfg_nxt;

    psk_byte_t   issue_dat, out_dat;
    logic        issue_vld, reg_rdy, out_vld;
    logic        src_rdy, psk_fire, is_last;

    psk_tx_out_reg u_out_reg (
        .clk     (clk_32d768M),
        .rst_n   (rst_n_32d768M),
        .in_vld  (issue_vld),
        .in_dat  (issue_dat),
        .in_rdy  (reg_rdy),
        .out_vld (out_vld),
        .out_dat (out_dat),
        .out_rdy (io.psk_tready)
    );

    assign io.psk_tvalid   = out_vld;
    assign io.psk_tdata    = out_dat.data;
    assign io.psk_tlast    = out_dat.last;
    assign io.psk_tuser    = out_dat.user;
    assign io.s_tready     = src_rdy;

    assign psk_fire        = out_vld && io.psk_tready;
    // cnt_q counts payload bytes already pushed into the output register
    assign is_last         = (cnt_q == len_q - 8'd1);

    assign TX_PHASE_CONFIG = phase_q;
    assign DELAY_CNT       = delay_q;
    assign busy            = (state_q != ST_IDLE);
    assign frame_done      = done_q;
    assign err_len         = err_len_q;
    assign err_cfg         = err_cfg_q;

    always_ff @(posedge clk_32d768M or negedge rst_n_32d768M) begin
        if (!rst_n_32d768M) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            len_q      <= '0;
            bpsk_q     <= 1'b0;
            phase_q    <= '0;
            delay_q    <= '0;
            err_len_q  <= 1'b0;
            src_done_q <= 1'b0;
            done_q     <= 1'b0;
            err_cfg_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            gap_q      <= gap_nxt;
            len_q      <= len_nxt;
            bpsk_q     <= bpsk_nxt;
            phase_q    <= phase_nxt;
            delay_q    <= delay_nxt;
            err_len_q  <= err_len_nxt;
            src_done_q <= src_done_nxt;
            done_q     <= done_nxt;
            err_cfg_q  <= err_cfg_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        gap_nxt      = gap_q;
        len_nxt      = len_q;
        bpsk_nxt     = bpsk_q;
        phase_nxt    = phase_q;
        delay_nxt    = delay_q;
        err_len_nxt  = err_len_q;
        src_done_nxt = src_done_q;
        done_nxt     = 1'b0;
        err_cfg_nxt  = 1'b0;
        issue_vld    = 1'b0;
        issue_dat    = '0;
        src_rdy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len == 8'd0) begin
                        err_cfg_nxt = 1'b1;
                    end else begin
                        len_nxt      = cfg_len;
                        bpsk_nxt     = cfg_bpsk;
                        phase_nxt    = cfg_phase_inc;
                        delay_nxt    = cfg_delay;
                        err_len_nxt  = 1'b0;
                        src_done_nxt = 1'b0;
                        // The output register is always empty here, so the first
                        // preamble byte is loaded in the start cycle itself.
                        issue_vld    = 1'b1;
                        issue_dat    = mk_byte(PRE_BYTE, 1'b0, 1'b1);
                        if (PRE_BYTES == 1) begin
                            state_nxt = ST_SYNC;
                            cnt_nxt   = 8'd0;
                        end else begin
                            state_nxt = ST_PRE;
                            cnt_nxt   = 8'd1;
                        end
                    end
                end
            end
            ST_PRE: begin
                if (reg_rdy) begin
                    issue_vld = 1'b1;
                    issue_dat = mk_byte(PRE_BYTE, 1'b0, 1'b1);
                    if (cnt_q == PRE_LAST) begin
                        state_nxt = ST_SYNC;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt   = cnt_q + 8'd1;
                    end
                end
            end
            ST_SYNC: begin
                if (reg_rdy) begin
                    issue_vld = 1'b1;
                    issue_dat = mk_byte(cnt_q[0] ? SYNC_WORD[7:0] : SYNC_WORD[15:8], 1'b0, 1'b1);
                    if (cnt_q[0]) begin
                        state_nxt = ST_LEN;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            ST_LEN: begin
                if (reg_rdy) begin
                    issue_vld = 1'b1;
                    issue_dat = mk_byte(len_q, 1'b0, 1'b1);
                    state_nxt = ST_PAY;
                    cnt_nxt   = 8'd0;
                end
            end
            ST_PAY: begin
                if (cnt_q != len_q) begin
                    if (src_done_q) begin
                        if (reg_rdy) begin
                            issue_vld = 1'b1;
                            issue_dat = mk_byte(PAD_BYTE, is_last, bpsk_q);
                            cnt_nxt   = cnt_q + 8'd1;
                        end
                    end else begin
                        src_rdy = reg_rdy;
                        if (io.s_tvalid && reg_rdy) begin
                            issue_vld = 1'b1;
                            issue_dat = mk_byte(io.s_tdata, is_last, bpsk_q);
                            cnt_nxt   = cnt_q + 8'd1;
                            if (io.s_tlast != is_last) begin
                                err_len_nxt = 1'b1;
                            end
                            if (io.s_tlast && !is_last) begin
                                src_done_nxt = 1'b1;
                            end
                        end
                    end
                end else if (psk_fire && out_dat.last) begin
                    done_nxt  = 1'b1;
                    gap_nxt   = GAP_LOAD;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (clk_16d384M) begin
                    gap_nxt = gap_q - 8'd1;
                    if (gap_q == 8'd1) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_psk_tx_frame_ctrl.sv
// Randomized bench for psk_tx_frame_ctrl against a frame-level reference model.
`timescale 1ns/1ps
module tb_psk_tx_frame_ctrl;
    import psk_tx_frame_ctrl_pkg::*;

    localparam int          PRE_BYTES  = 8;
    localparam int          GAP_CYCLES = 64;
    localparam logic [15:0] SYNC       = 16'hD391;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = 8'd0;
    logic        cfg_bpsk = 1'b0;
    logic [15:0] cfg_phase_inc = 16'd0;
    logic [3:0]  cfg_delay = 4'd0;
    logic [15:0] tx_phase;
    logic [3:0]  delay_cnt;
    logic        busy, frame_done, err_len, err_cfg;

    psk_tx_frame_ctrl_if bus ();

    psk_tx_frame_ctrl #(
        .PRE_BYTES  (PRE_BYTES),
        .SYNC_WORD  (SYNC),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk_32d768M     (clk),
        .rst_n_32d768M   (rst_n),
        .clk_16d384M     (en),
        .start           (start),
        .cfg_len         (cfg_len),
        .cfg_bpsk        (cfg_bpsk),
        .cfg_phase_inc   (cfg_phase_inc),
        .cfg_delay       (cfg_delay),
        .io              (bus),
        .TX_PHASE_CONFIG (tx_phase),
        .DELAY_CNT       (delay_cnt),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_len         (err_len),
        .err_cfg         (err_cfg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {tlast, tdata} per source byte; observed modulator bytes as {tuser, tlast, tdata}
    logic [8:0] src_q[$];
    logic [9:0] out_q[$];
    int         src_idx, cons_cnt, fd_cnt, ec_cnt, gap_en, hold_viol;
    bit         src_rnd, sink_rnd, in_gap, hold_chk;
    logic [9:0] hold_val;

    task automatic step();
        logic [9:0] cur;
        @(negedge clk);
        cur = {bus.psk_tuser, bus.psk_tlast, bus.psk_tdata};
        if (hold_chk && (!bus.psk_tvalid || cur !== hold_val)) hold_viol++;
        hold_chk = bus.psk_tvalid && !bus.psk_tready;
        hold_val = cur;
        if (bus.psk_tvalid && bus.psk_tready) out_q.push_back(cur);
        if (bus.s_tvalid && bus.s_tready) begin
            cons_cnt++;
            src_idx++;
        end
        if (frame_done) begin
            fd_cnt++;
            in_gap = 1'b1;
        end
        if (err_cfg) ec_cnt++;
        if (in_gap && busy) gap_en += int'(en);
        @(posedge clk);
        #1;
        en = ~en;
        bus.psk_tready = sink_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (src_idx < src_q.size()) begin
            bus.s_tvalid = src_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_tdata  = src_q[src_idx][7:0];
            bus.s_tlast  = src_q[src_idx][8];
        end else begin
            bus.s_tvalid = 1'b0;
            bus.s_tdata  = 8'd0;
            bus.s_tlast  = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_psk"}, 32'({bus.psk_tvalid, bus.psk_tdata, bus.psk_tlast, bus.psk_tuser, bus.s_tready}), 32'd0);
        check({tag, "_ctl"}, 32'({busy, frame_done, err_len, err_cfg, tx_phase, delay_cnt}), 32'd0);
    endtask

    // tl_pos: 1-based source position carrying tlast, 0 for none
    task automatic run_frame(input int fno, input int len, input bit bpsk, input int tl_pos,
                             input bit seq_data, input bit rnd, input bit gap_start, input bit rst_mid);
        logic [8:0]  b;
        logic [9:0]  exp_q[$];
        int          consumed;
        bit          exp_err, done_src, fin;
        logic [15:0] ph;
        logic [3:0]  dl;
        string       p;
        p = $sformatf("f%0d_", fno);
        src_q.delete();
        src_idx = 0;
        for (int i = 0; i < len + 2; i++) begin
            b[7:0] = seq_data ? 8'(i + 1) : 8'($urandom);
            b[8]   = (i + 1 == tl_pos);
            src_q.push_back(b);
        end
        out_q.delete();
        cons_cnt = 0; fd_cnt = 0; ec_cnt = 0; gap_en = 0; hold_viol = 0; in_gap = 1'b0;
        src_rnd = rnd; sink_rnd = rnd;
        ph = 16'($urandom);
        dl = 4'($urandom);
        start = 1'b1; cfg_len = 8'(len); cfg_bpsk = bpsk; cfg_phase_inc = ph; cfg_delay = dl;
        step();
        start = 1'b0; cfg_len = 8'($urandom); cfg_bpsk = ~bpsk; cfg_phase_inc = ~ph; cfg_delay = ~dl;
        check({p, "tvalid_rise"}, 32'(bus.psk_tvalid), 32'd1);
        check({p, "busy_rise"}, 32'(busy), 32'd1);
        fin = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (rst_mid && out_q.size() >= PRE_BYTES + 4) begin
                rst_n = 1'b0;
                #1;
                check_reset_vals({p, "rst_mid"});
                hold_chk = 1'b0;
                step();
                rst_n = 1'b1;
                src_q.delete();
                return;
            end
            if (gap_start && in_gap && gap_en == 10) begin
                start = 1'b1;
                cfg_len = 8'd3;
            end
            if (gap_start && gap_en >= 20) start = 1'b0;
            step();
            if (!busy) begin
                fin = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({p, "finished"}, 32'(fin), 32'd1);

        for (int i = 0; i < PRE_BYTES; i++) exp_q.push_back({2'b10, PRE_BYTE});
        exp_q.push_back({2'b10, SYNC[15:8]});
        exp_q.push_back({2'b10, SYNC[7:0]});
        exp_q.push_back({2'b10, 8'(len)});
        done_src = 1'b0; consumed = 0; exp_err = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (!done_src) begin
                b = src_q[i];
                consumed++;
                if (b[8]) begin
                    done_src = 1'b1;
                    exp_err  = (i != len - 1);
                end
            end else begin
                b = {1'b0, PAD_BYTE};
            end
            exp_q.push_back({bpsk, 1'(i == len - 1), b[7:0]});
        end

        check({p, "n_bytes"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%sbyte%0d", p, i), 32'(out_q[i]), 32'(exp_q[i]));
        check({p, "src_taken"}, 32'(cons_cnt), 32'(consumed));
        check({p, "frame_done"}, 32'(fd_cnt), 32'd1);
        check({p, "err_len"}, 32'(err_len), 32'(exp_err));
        check({p, "gap_len"}, 32'(gap_en), 32'(GAP_CYCLES));
        check({p, "hold"}, 32'(hold_viol), 32'd0);
        check({p, "cfg_out"}, 32'({tx_phase, delay_cnt}), 32'({ph, dl}));
        check({p, "err_cfg"}, 32'(ec_cnt), 32'd0);
        repeat (3) step();
        check({p, "idle_after"}, 32'({busy, bus.psk_tvalid}), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, tl, r, busy_seen;
        bus.s_tdata = 8'd0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.psk_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        step();
        step();

        run_frame(1, 4, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(2, 6, 1'b0, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(3, 4, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(4, 5, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0);

        ec_cnt = 0;
        busy_seen = 0;
        cfg_len = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            busy_seen += int'(busy);
            step();
        end
        check("lenzero_err_cfg", 32'(ec_cnt), 32'd1);
        check("lenzero_busy", 32'(busy_seen), 32'd0);

        run_frame(5, 3, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(6, 10, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b1);
        run_frame(7, 4, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(8, 1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(9, 7, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(10, 255, 1'b1, 255, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int f = 11; f < 23; f++) begin
            len = $urandom_range(1, 24);
            r = $urandom_range(0, 3);
            case (r)
                0:       tl = len;
                1:       tl = 0;
                2:       tl = $urandom_range(1, len);
                default: tl = len + 1;
            endcase
            run_frame(f, len, 1'($urandom_range(0, 1)), tl, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
